// File: rtl/mii_tx_framer.sv
// mii_tx_framer: transmit-side MII framer.
// Pops payload bytes from a first-word-fall-through TX FIFO and sends an
// Ethernet frame as MII nibbles. The frame is preamble, SFD, payload, optional
// zero padding up to MIN_PAYLOAD bytes, and the CRC32 FCS. An inter-frame gap
// follows every frame. A FIFO underrun mid-frame raises TX_ER for one clock
// and drops the rest of that frame from the FIFO.
// Ports:
//   clk, rst_n         PHY tx clock; synchronous active-low reset
//   fifo_data/last     FIFO head byte and its end-of-frame flag
//   fifo_empty         FIFO empty
//   fifo_read          one-cycle pop of the FIFO head
//   phy_tx_en/txd/err  MII transmit pins
//   busy               framer not idle
//   frame_done         pulse after a completed frame's last FCS nibble
//   underrun           pulse when the FIFO runs dry mid-frame
// All outputs are registered, so the pins show the nibble chosen for the
// current state one clock later.
module mii_tx_framer #(
    parameter int MIN_PAYLOAD = 60,
    parameter bit PAD_EN      = 1'b1,
    parameter int IFG_NIBBLES = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] fifo_data,
    input  logic       fifo_last,
    input  logic       fifo_empty,
    output logic       fifo_read,
    output logic       phy_tx_en,
    output logic [3:0] phy_txd,
    output logic       phy_tx_err,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_SFD     = 3'd2,
        ST_DATA    = 3'd3,
        ST_PAD     = 3'd4,
        ST_FCS     = 3'd5,
        ST_IFG     = 3'd6,
        ST_DISCARD = 3'd7
    } state_t;

    // PRE sends 14 nibbles of 5. SFD then sends 5,D, so the wire carries 15 x 5 followed by D.
    localparam logic [7:0]  PRE_LAST  = 8'd13;
    // The IDLE state also shows one idle nibble, so IFG holds one clock less.
    localparam logic [7:0]  IFG_LAST  = 8'(IFG_NIBBLES - 2);
    localparam logic [15:0] MIN_BYTES = 16'(MIN_PAYLOAD);
    localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;

    // Reflected CRC32 update over one nibble, LSB first.
    function automatic logic [31:0] crc_nib(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        c = crc ^ {28'd0, nib};
        for (int i = 0; i < 4; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        phase_r, phase_s;
    logic [7:0]  byte_r, byte_s;
    logic        last_r, last_s;
    logic [15:0] pay_cnt_r, pay_cnt_s;
    logic [31:0] crc_r, crc_s;
    logic        ok_r, ok_s;
    logic        tx_en_r, tx_en_s;
    logic [3:0]  txd_r, txd_s;
    logic        err_r, err_s;
    logic        read_r, read_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        und_r, und_s;
    logic [31:0] fcs_s;

    // State, datapath and registered output flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            phase_r   <= 1'b0;
            byte_r    <= 8'd0;
            last_r    <= 1'b0;
            pay_cnt_r <= 16'd0;
            crc_r     <= CRC_INIT;
            ok_r      <= 1'b0;
            tx_en_r   <= 1'b0;
            txd_r     <= 4'd0;
            err_r     <= 1'b0;
            read_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            und_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            phase_r   <= phase_s;
            byte_r    <= byte_s;
            last_r    <= last_s;
            pay_cnt_r <= pay_cnt_s;
            crc_r     <= crc_s;
            ok_r      <= ok_s;
            tx_en_r   <= tx_en_s;
            txd_r     <= txd_s;
            err_r     <= err_s;
            read_r    <= read_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            und_r     <= und_s;
        end
    end

    // Next-state, counter, byte latch and CRC update.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        phase_s   = phase_r;
        byte_s    = byte_r;
        last_s    = last_r;
        pay_cnt_s = pay_cnt_r;
        crc_s     = crc_r;
        ok_s      = ok_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_s = ST_PRE;
                    cnt_s   = 8'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (cnt_r == PRE_LAST) begin
                    state_s = ST_SFD;
                    cnt_s   = 8'd0;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_SFD: begin
                crc_s     = CRC_INIT;
                pay_cnt_s = 16'd0;
                last_s    = 1'b0;
                phase_s   = 1'b0;
                ok_s      = 1'b0;
                if (cnt_r == 8'd1) begin
                    state_s = ST_DATA;
                    cnt_s   = 8'd0;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_DATA: begin
                if (!phase_r) begin
                    if (fifo_empty) begin
                        // The frame's last byte is still in the FIFO unless it was already taken.
                        state_s = last_r ? ST_IFG : ST_DISCARD;
                        cnt_s   = 8'd0;
                        phase_s = 1'b0;
                    end else begin
                        byte_s    = fifo_data;
                        last_s    = fifo_last;
                        phase_s   = 1'b1;
                        pay_cnt_s = (pay_cnt_r < MIN_BYTES) ? (pay_cnt_r + 16'd1) : pay_cnt_r;
                        crc_s     = crc_nib(crc_r, fifo_data[3:0]);
                    end
                end else begin
                    crc_s   = crc_nib(crc_r, byte_r[7:4]);
                    phase_s = 1'b0;
                    if (last_r) begin
                        state_s = (PAD_EN && (pay_cnt_r < MIN_BYTES)) ? ST_PAD : ST_FCS;
                        cnt_s   = 8'd0;
                    end else begin
                        state_s = ST_DATA;
                    end
                end
            end
            ST_PAD: begin
                crc_s   = crc_nib(crc_r, 4'h0);
                phase_s = ~phase_r;
                if (phase_r) begin
                    pay_cnt_s = pay_cnt_r + 16'd1;
                    if ((pay_cnt_r + 16'd1) >= MIN_BYTES) begin
                        state_s = ST_FCS;
                        cnt_s   = 8'd0;
                    end else begin
                        state_s = ST_PAD;
                    end
                end else begin
                    state_s = ST_PAD;
                end
            end
            ST_FCS: begin
                if (cnt_r == 8'd7) begin
                    state_s = ST_IFG;
                    cnt_s   = 8'd0;
                    ok_s    = 1'b1;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_IFG: begin
                if (cnt_r == IFG_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = 8'd0;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_DISCARD: begin
                // Pop on phase 0. Phase 1 waits for the registered pop to land, which exposes the next head.
                if (!phase_r) begin
                    if (!fifo_empty) begin
                        if (fifo_last) begin
                            state_s = ST_IFG;
                            cnt_s   = 8'd0;
                            phase_s = 1'b0;
                        end else begin
                            phase_s = 1'b1;
                        end
                    end else begin
                        phase_s = 1'b0;
                    end
                end else begin
                    phase_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode; these values reach the pins on the next edge.
    always_comb begin
        tx_en_s = 1'b0;
        txd_s   = 4'h0;
        err_s   = 1'b0;
        read_s  = 1'b0;
        done_s  = 1'b0;
        und_s   = 1'b0;
        fcs_s   = ~crc_r;
        busy_s  = (state_s != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                tx_en_s = 1'b0;
            end
            ST_PRE: begin
                tx_en_s = 1'b1;
                txd_s   = 4'h5;
            end
            ST_SFD: begin
                tx_en_s = 1'b1;
                txd_s   = (cnt_r == 8'd0) ? 4'h5 : 4'hD;
            end
            ST_DATA: begin
                tx_en_s = 1'b1;
                if (!phase_r) begin
                    if (fifo_empty) begin
                        err_s = 1'b1;
                        und_s = 1'b1;
                    end else begin
                        txd_s  = fifo_data[3:0];
                        read_s = 1'b1;
                    end
                end else begin
                    txd_s = byte_r[7:4];
                end
            end
            ST_PAD: begin
                tx_en_s = 1'b1;
            end
            ST_FCS: begin
                tx_en_s = 1'b1;
                txd_s   = fcs_s[{cnt_r[2:0], 2'b00} +: 4];
            end
            ST_IFG: begin
                done_s = (cnt_r == 8'd0) && ok_r;
            end
            ST_DISCARD: begin
                read_s = !phase_r && !fifo_empty;
            end
            default: begin
                tx_en_s = 1'b0;
            end
        endcase
    end

    assign fifo_read  = read_r;
    assign phy_tx_en  = tx_en_r;
    assign phy_txd    = txd_r;
    assign phy_tx_err = err_r;
    assign busy       = busy_r;
    assign frame_done = done_r;
    assign underrun   = und_r;

endmodule

// File: tb/tb_mii_tx_framer.sv
// Bench for mii_tx_framer: a queue-based FIFO model feeds one of two DUTs
// (PAD_EN=0 / PAD_EN=1). A byte-wise CRC32 reference builds each frame's
// expected nibble stream, which is compared with the stream seen on TX_EN.
module tb_mii_tx_framer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sel;
    logic [7:0] fifo_data;
    logic       fifo_last;
    logic       fe;
    logic       fe0, fe1;
    logic       rd0, en0, err0, busy0, done0, und0;
    logic       rd1, en1, err1, busy1, done1, und1;
    logic [3:0] txd0, txd1;

    assign fe0 = sel ? 1'b1 : fe;
    assign fe1 = sel ? fe : 1'b1;

    mii_tx_framer #(.MIN_PAYLOAD(60), .PAD_EN(1'b0), .IFG_NIBBLES(24)) dut0 (
        .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_last(fifo_last),
        .fifo_empty(fe0), .fifo_read(rd0), .phy_tx_en(en0), .phy_txd(txd0),
        .phy_tx_err(err0), .busy(busy0), .frame_done(done0), .underrun(und0));

    mii_tx_framer #(.MIN_PAYLOAD(60), .PAD_EN(1'b1), .IFG_NIBBLES(24)) dut1 (
        .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_last(fifo_last),
        .fifo_empty(fe1), .fifo_read(rd1), .phy_tx_en(en1), .phy_txd(txd1),
        .phy_tx_err(err1), .busy(busy1), .frame_done(done1), .underrun(und1));

    logic       m_en, m_read, m_err, m_busy, m_done, m_und;
    logic [3:0] m_txd;
    assign m_en   = sel ? en1 : en0;
    assign m_txd  = sel ? txd1 : txd0;
    assign m_read = sel ? rd1 : rd0;
    assign m_err  = sel ? err1 : err0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_und  = sel ? und1 : und0;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] q[$];
    logic [7:0] pl_q[$];
    logic [3:0] exp_q[$];
    logic [3:0] wire_q[$];
    int         gap_q[$];
    int         txen_cnt, read_cnt, done_cnt, under_cnt, err_cnt, cur_gap;
    int         bad_read = 0;
    bit         seen_en;

    // Monitor and FIFO model: sample DUT pins, then apply the pop, away from the rising edge.
    always @(negedge clk) begin
        if (m_en) begin
            wire_q.push_back(m_txd);
            txen_cnt++;
            if (seen_en && cur_gap > 0) gap_q.push_back(cur_gap);
            cur_gap = 0;
            seen_en = 1'b1;
        end else if (seen_en) begin
            cur_gap++;
        end
        if (rd0 && fe0) bad_read++;
        if (rd1 && fe1) bad_read++;
        if (m_read) begin
            read_cnt++;
            if (q.size() > 0) void'(q.pop_front());
        end
        if (m_done) done_cnt++;
        if (m_und) under_cnt++;
        if (m_err) err_cnt++;
        if (q.size() > 0) begin
            {fifo_last, fifo_data} = q[0];
            fe = 1'b0;
        end else begin
            fifo_last = 1'b0;
            fifo_data = 8'h00;
            fe = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wire_q.delete();
        gap_q.delete();
        exp_q.delete();
        txen_cnt = 0; read_cnt = 0; done_cnt = 0; under_cnt = 0; err_cnt = 0;
        cur_gap = 0; seen_en = 1'b0;
    endtask

    task automatic rand_payload(input int len);
        pl_q.delete();
        for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom));
    endtask

    task automatic push_frame();
        for (int i = 0; i < pl_q.size(); i++) q.push_back({(i == pl_q.size() - 1), pl_q[i]});
    endtask

    // Reference frame: 15 x 5, D, payload (+ zero pad) low nibble first, then ~CRC32 low nibble first.
    task automatic model_frame(input bit pad);
        logic [7:0]  b[$];
        logic [31:0] crc;
        b = pl_q;
        if (pad) while (b.size() < 60) b.push_back(8'h00);
        crc = 32'hFFFFFFFF;
        foreach (b[i]) begin
            crc = crc ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        crc = ~crc;
        for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        foreach (b[i]) begin
            exp_q.push_back(b[i][3:0]);
            exp_q.push_back(b[i][7:4]);
        end
        for (int k = 0; k < 8; k++) exp_q.push_back(crc[4*k +: 4]);
    endtask

    task automatic wait_done(input int n, input string name);
        int k = 0;
        while (!(done_cnt >= n && !m_busy) && k < 3000) begin
            tick();
            k++;
        end
        checks++;
        if (k >= 3000) begin
            errors++;
            $display("FAIL %s timeout: frame_done count %0d, required %0d", name, done_cnt, n);
        end
    endtask

    task automatic compare_stream(input string name);
        int bad = -1;
        checks++;
        if (wire_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s stream length: got %0d nibbles, expected %0d", name, wire_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && wire_q[i] !== exp_q[i]) bad = i;
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s stream nibble %0d: got %h expected %h", name, bad, wire_q[bad], exp_q[bad]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({en1, txd1, err1, rd1, busy1, done1, und1} !== 10'd0) begin
            errors++;
            $display("FAIL reset_dut1: got %b expected 0", {en1, txd1, err1, rd1, busy1, done1, und1});
        end
        checks++;
        if ({en0, txd0, err0, rd0, busy0, done0, und0} !== 10'd0) begin
            errors++;
            $display("FAIL reset_dut0: got %b expected 0", {en0, txd0, err0, rd0, busy0, done0, und0});
        end
        rst_n = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (busy1 !== 1'b0 || en1 !== 1'b0) begin
            errors++;
            $display("FAIL idle_empty: busy %b tx_en %b expected 0 0", busy1, en1);
        end
    endtask

    task automatic test_known_vector();
        logic [3:0] fcs_ref[8] = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
        sel = 1'b0;
        clear_mon();
        pl_q.delete();
        for (int i = 0; i < 9; i++) pl_q.push_back(8'h31 + 8'(i));
        model_frame(1'b0);
        push_frame();
        wait_done(1, "vector");
        compare_stream("vector");
        checks++;
        if (txen_cnt != 42) begin
            errors++;
            $display("FAIL vector tx_en clocks: got %0d expected 42", txen_cnt);
        end
        checks++;
        if (wire_q.size() != 42) begin
            errors++;
            $display("FAIL vector fcs: got %0d nibbles expected 42", wire_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (wire_q[34 + k] !== fcs_ref[k]) begin
                    errors++;
                    $display("FAIL vector fcs nibble %0d: got %h expected %h", k, wire_q[34 + k], fcs_ref[k]);
                    break;
                end
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL vector frame_done: got %0d expected 1", done_cnt);
        end
        checks++;
        if (read_cnt != 9) begin
            errors++;
            $display("FAIL vector fifo_read: got %0d expected 9", read_cnt);
        end
    endtask

    task automatic test_pad();
        sel = 1'b1;
        clear_mon();
        pl_q.delete();
        pl_q.push_back(8'hAB);
        model_frame(1'b1);
        push_frame();
        wait_done(1, "pad");
        compare_stream("pad");
        checks++;
        if (txen_cnt != 144) begin
            errors++;
            $display("FAIL pad tx_en clocks: got %0d expected 144", txen_cnt);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            int len;
            sel = (f != 5);
            clear_mon();
            len = $urandom_range(1, 75);
            rand_payload(len);
            model_frame(sel);
            push_frame();
            wait_done(1, "random");
            compare_stream("random");
            checks++;
            if (read_cnt != len) begin
                errors++;
                $display("FAIL random fifo_read: got %0d expected %0d", read_cnt, len);
            end
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        clear_mon();
        rand_payload($urandom_range(1, 20));
        model_frame(1'b1);
        push_frame();
        rand_payload($urandom_range(50, 70));
        model_frame(1'b1);
        push_frame();
        wait_done(2, "b2b");
        compare_stream("b2b");
        checks++;
        if (gap_q.size() != 1 || gap_q[0] != 24) begin
            errors++;
            $display("FAIL b2b gap: got %0d gaps first %0d expected 1 gap of 24", gap_q.size(),
                     (gap_q.size() > 0) ? gap_q[0] : -1);
        end
    endtask

    task automatic test_underrun();
        int k = 0;
        sel = 1'b1;
        clear_mon();
        rand_payload(5);
        for (int i = 0; i < 5; i++) q.push_back({1'b0, pl_q[i]});
        for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        foreach (pl_q[i]) begin
            exp_q.push_back(pl_q[i][3:0]);
            exp_q.push_back(pl_q[i][7:4]);
        end
        exp_q.push_back(4'h0);
        while (under_cnt == 0 && k < 500) begin
            tick();
            k++;
        end
        for (int i = 0; i < 3; i++) q.push_back({(i == 2), 8'($urandom)});
        while ((m_busy || q.size() > 0) && k < 1000) begin
            tick();
            k++;
        end
        checks++;
        if (k >= 1000) begin
            errors++;
            $display("FAIL underrun timeout: busy %b fifo entries %0d", m_busy, q.size());
        end
        compare_stream("underrun");
        checks++;
        if (err_cnt != 1 || under_cnt != 1) begin
            errors++;
            $display("FAIL underrun pulses: tx_err %0d underrun %0d expected 1 1", err_cnt, under_cnt);
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL underrun frame_done: got %0d expected 0", done_cnt);
        end
        checks++;
        if (read_cnt != 8) begin
            errors++;
            $display("FAIL underrun fifo_read: got %0d expected 8", read_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        sel = 1'b1;
        clear_mon();
        rand_payload(30);
        push_frame();
        while (txen_cnt < 26 && k < 500) begin
            tick();
            k++;
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (en1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: tx_en %b busy %b expected 0 0", en1, busy1);
        end
        rst_n = 1'b1;
        q.delete();
        clear_mon();
        tick();
        rand_payload($urandom_range(5, 40));
        model_frame(1'b1);
        push_frame();
        wait_done(1, "after_reset");
        compare_stream("after_reset");
    endtask

    task automatic test_reset_release();
        sel = 1'b1;
        rst_n = 1'b0;
        tick();
        clear_mon();
        rand_payload(10);
        model_frame(1'b1);
        push_frame();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (en1 !== 1'b0) begin
            errors++;
            $display("FAIL release edge1 tx_en: got %b expected 0", en1);
        end
        tick();
        checks++;
        if (en1 !== 1'b1 || txd1 !== 4'h5) begin
            errors++;
            $display("FAIL release edge2: tx_en %b txd %h expected 1 5", en1, txd1);
        end
        wait_done(1, "release");
        compare_stream("release");
    endtask

    initial begin
        rst_n = 1'b0;
        sel = 1'b1;
        fe = 1'b1;
        fifo_data = 8'h00;
        fifo_last = 1'b0;
        clear_mon();
        test_reset();
        test_known_vector();
        test_pad();
        test_random();
        test_back_to_back();
        test_underrun();
        test_reset_mid();
        test_reset_release();
        checks++;
        if (bad_read != 0) begin
            errors++;
            $display("FAIL read_while_empty: got %0d pops expected 0", bad_read);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
